// File: rtl/ex_alu_s2_pkg.sv
// Shared definitions for the second integer-ALU pipeline stage:
// default widths, the hardwired-zero register index and the skid occupancy states.
package ex_alu_s2_pkg;

    localparam int DEFAULT_DATA_W = 64;
    localparam int DEFAULT_RD_W   = 6;

    // Register r0 reads as zero, so writes to it are squashed at capture
    localparam int REG_ZERO_IDX   = 0;

    // Occupancy of the two-entry skid buffer; the skid entry is only ever
    // full while the head entry is also full, so (0,1) has no encoding
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_HEAD  = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/ex_alu_s2_skid_buf.sv
// Generic two-entry skid buffer with valid/ready on both sides and a flush.
// in_ready depends only on registered occupancy, so there is no combinational
// path from the downstream ready back to the producer.
module ex_alu_s2_skid_buf
    import ex_alu_s2_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] head_data,
    output logic             skid_valid,
    output logic [WIDTH-1:0] skid_data
);

    occ_e occ;
    occ_e occ_next;

    logic accept;
    logic pop;
    logic load_head_in;
    logic load_head_skid;
    logic load_skid;

    // Handshake qualifiers; everything is held off while reset is asserted
    assign in_ready   = rst_n & (occ != OCC_FULL);
    assign out_valid  = rst_n & (occ != OCC_EMPTY);
    assign skid_valid = rst_n & (occ == OCC_FULL);
    assign accept     = in_valid & in_ready & ~flush;
    assign pop        = out_valid & out_ready;

    // Occupancy register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ <= OCC_EMPTY;
        end else begin
            occ <= occ_next;
        end
    end

    // Next occupancy and which entry loads what; flush wins over any traffic
    always_comb begin
        occ_next       = occ;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            occ_next = OCC_EMPTY;
        end else begin
            case (occ)
                OCC_EMPTY: begin
                    if (accept) begin
                        load_head_in = 1'b1;
                        occ_next     = OCC_HEAD;
                    end
                end
                OCC_HEAD: begin
                    if (accept && pop) begin
                        load_head_in = 1'b1;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        occ_next  = OCC_FULL;
                    end else if (pop) begin
                        occ_next = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        load_head_skid = 1'b1;
                        occ_next       = OCC_HEAD;
                    end
                end
                default: begin
                    occ_next = OCC_EMPTY;
                end
            endcase
        end
    end

    // Entry payload registers; they need not clear on flush because the
    // valids already hide them
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_data <= '0;
            skid_data <= '0;
        end else begin
            if (load_head_in) begin
                head_data <= in_data;
            end else if (load_head_skid) begin
                head_data <= skid_data;
            end
            if (load_skid) begin
                skid_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/ex_alu_s2.sv
// Second integer-ALU stage: registers the stage-1 result with its destination
// tag and write-enable, hands it to writeback through a skid buffer, and
// exposes both buffered entries as forwarding sources.
module ex_alu_s2
    import ex_alu_s2_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int RD_W   = DEFAULT_RD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_wb_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_wb_en,
    output logic              fwd0_valid,
    output logic [RD_W-1:0]   fwd0_rd,
    output logic [DATA_W-1:0] fwd0_result,
    output logic              fwd1_valid,
    output logic [RD_W-1:0]   fwd1_rd,
    output logic [DATA_W-1:0] fwd1_result
);

    // Entry layout, MSB first: {wb_en, rd, result}
    localparam int ENTRY_W = 1 + RD_W + DATA_W;

    logic               cap_wb_en;
    logic [ENTRY_W-1:0] in_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic [ENTRY_W-1:0] skid_entry;
    logic               skid_valid;

    // r0 is hardwired zero, so a write to it never reaches writeback or the
    // bypass network; the result itself is still carried along
    assign cap_wb_en = in_wb_en & (in_rd != RD_W'(REG_ZERO_IDX));
    assign in_entry  = {cap_wb_en, in_rd, in_result};

    ex_alu_s2_skid_buf #(
        .WIDTH (ENTRY_W)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_entry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .head_data  (head_entry),
        .skid_valid (skid_valid),
        .skid_data  (skid_entry)
    );

    assign out_wb_en  = head_entry[ENTRY_W-1];
    assign out_rd     = head_entry[DATA_W +: RD_W];
    assign out_result = head_entry[DATA_W-1:0];

    // The consumer prefers fwd1 when both match, since the skid entry is younger
    assign fwd0_valid  = out_valid & head_entry[ENTRY_W-1];
    assign fwd0_rd     = head_entry[DATA_W +: RD_W];
    assign fwd0_result = head_entry[DATA_W-1:0];
    assign fwd1_valid  = skid_valid & skid_entry[ENTRY_W-1];
    assign fwd1_rd     = skid_entry[DATA_W +: RD_W];
    assign fwd1_result = skid_entry[DATA_W-1:0];

endmodule

// File: tb/tb_ex_alu_s2.sv
// Self-checking bench for ex_alu_s2: a queue model of the buffer contents acts
// as scoreboard, filled when a beat is accepted and drained when writeback pops.
module tb_ex_alu_s2;

    typedef struct packed {
        logic        wb;
        logic [5:0]  rd;
        logic [63:0] res;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_result;
    logic [5:0]  in_rd;
    logic        in_wb_en;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [5:0]  out_rd;
    logic        out_wb_en;
    logic        fwd0_valid;
    logic [5:0]  fwd0_rd;
    logic [63:0] fwd0_result;
    logic        fwd1_valid;
    logic [5:0]  fwd1_rd;
    logic [63:0] fwd1_result;

    int   n_tests;
    int   n_fail;
    int   accepted;
    ent_t model_q[$];

    ex_alu_s2 #(
        .DATA_W (64),
        .RD_W   (6)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_result   (in_result),
        .in_rd       (in_rd),
        .in_wb_en    (in_wb_en),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_wb_en   (out_wb_en),
        .fwd0_valid  (fwd0_valid),
        .fwd0_rd     (fwd0_rd),
        .fwd0_result (fwd0_result),
        .fwd1_valid  (fwd1_valid),
        .fwd1_rd     (fwd1_rd),
        .fwd1_result (fwd1_result)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drives one cycle of inputs, checks outputs against the model mid-cycle,
    // then advances the model by what the handshake at the next edge does.
    task automatic applyStimulus(input logic v, input logic [63:0] res, input logic [5:0] rd,
                                 input logic wb, input logic ordy, input logic fl);
        logic [3:0] exp_status;
        logic       ir0;
        logic       acc;
        logic       pop;
        ent_t       e;
        in_valid  = v;
        in_result = res;
        in_rd     = rd;
        in_wb_en  = wb;
        out_ready = ordy;
        flush     = fl;
        #1;
        ir0 = in_ready;
        out_ready = ~ordy;
        in_valid  = ~v;
        #1;
        checkOutput("comb_path", 128'(in_ready), 128'(ir0));
        out_ready = ordy;
        in_valid  = v;
        @(negedge clk);
        if (!rst_n) begin
            exp_status = 4'b0000;
        end else begin
            exp_status[3] = (model_q.size() < 2);
            exp_status[2] = (model_q.size() > 0);
            exp_status[1] = (model_q.size() > 0) && model_q[0].wb;
            exp_status[0] = (model_q.size() > 1) && model_q[1].wb;
        end
        checkOutput("status", 128'({in_ready, out_valid, fwd0_valid, fwd1_valid}), 128'(exp_status));
        if (rst_n && model_q.size() > 0) begin
            checkOutput("head", 128'({out_wb_en, out_rd, out_result}), 128'(model_q[0]));
            checkOutput("fwd0", 128'({fwd0_rd, fwd0_result}), 128'({model_q[0].rd, model_q[0].res}));
        end
        if (rst_n && model_q.size() > 1) begin
            checkOutput("fwd1", 128'({fwd1_rd, fwd1_result}), 128'({model_q[1].rd, model_q[1].res}));
        end
        acc = rst_n && v && (model_q.size() < 2) && !fl;
        pop = rst_n && ordy && (model_q.size() > 0);
        if (!rst_n || fl) begin
            model_q.delete();
        end else begin
            if (pop) void'(model_q.pop_front());
            if (acc) begin
                e.wb  = wb && (rd != 6'd0);
                e.rd  = rd;
                e.res = res;
                model_q.push_back(e);
                accepted++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cycles;
        n_tests   = 0;
        n_fail    = 0;
        accepted  = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_result = '0;
        in_rd     = '0;
        in_wb_en  = 1'b0;
        out_ready = 1'b0;

        // Reset held three cycles with a beat on offer
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 64'hDEAD, 6'd9, 1'b1, 1'b1, 1'b0);
        checkOutput("reset_out_valid", 128'(out_valid), 128'(0));
        rst_n = 1'b1;
        #1;
        checkOutput("ready_after_reset", 128'(in_ready), 128'(1));
        applyStimulus(1'b0, 64'h0, 6'd0, 1'b0, 1'b1, 1'b0);

        // Single beat straight through
        applyStimulus(1'b1, 64'h1234, 6'd5, 1'b1, 1'b1, 1'b0);
        checkOutput("single_valid", 128'(out_valid), 128'(1));
        checkOutput("single_result", 128'(out_result), 128'(64'h1234));
        checkOutput("single_rd", 128'(out_rd), 128'(5));
        checkOutput("single_fwd0", 128'(fwd0_valid), 128'(1));
        applyStimulus(1'b0, 64'h0, 6'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("single_gone", 128'(out_valid), 128'(0));

        // Stall fills head then skid; a third beat must wait
        applyStimulus(1'b1, 64'hA, 6'd1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'hB, 6'd2, 1'b1, 1'b0, 1'b0);
        checkOutput("stall_in_ready", 128'(in_ready), 128'(0));
        checkOutput("stall_fwd0_rd", 128'(fwd0_rd), 128'(1));
        checkOutput("stall_fwd1_rd", 128'(fwd1_rd), 128'(2));
        applyStimulus(1'b1, 64'hC, 6'd3, 1'b1, 1'b0, 1'b0);
        checkOutput("stall_hold_rd", 128'(out_rd), 128'(1));
        applyStimulus(1'b1, 64'hC, 6'd3, 1'b1, 1'b1, 1'b0);
        checkOutput("drain_b", 128'(out_result), 128'(64'hB));
        applyStimulus(1'b1, 64'hC, 6'd3, 1'b1, 1'b1, 1'b0);
        checkOutput("drain_c", 128'(out_result), 128'(64'hC));
        applyStimulus(1'b0, 64'h0, 6'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("drain_empty", 128'(out_valid), 128'(0));

        // Write to r0 keeps the result but drops the write-enable
        applyStimulus(1'b1, 64'hFFFF, 6'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("r0_valid", 128'(out_valid), 128'(1));
        checkOutput("r0_wb_en", 128'(out_wb_en), 128'(0));
        checkOutput("r0_fwd0", 128'(fwd0_valid), 128'(0));
        checkOutput("r0_result", 128'(out_result), 128'(64'hFFFF));
        applyStimulus(1'b0, 64'h0, 6'd0, 1'b0, 1'b1, 1'b0);

        // Flush with both entries full and a beat on offer
        applyStimulus(1'b1, 64'h55, 6'd10, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h66, 6'd11, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h77, 6'd12, 1'b1, 1'b0, 1'b1);
        checkOutput("flush_out_valid", 128'(out_valid), 128'(0));
        checkOutput("flush_in_ready", 128'(in_ready), 128'(1));
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 64'h0, 6'd0, 1'b0, 1'b1, 1'b0);

        // Random traffic with occasional flushes, scored by the model queue
        accepted = 0;
        cycles   = 0;
        while (accepted < 10000 && cycles < 60000) begin
            applyStimulus(1'($urandom_range(0, 1)), {$urandom, $urandom}, 6'($urandom_range(0, 63)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 99) == 0));
            cycles++;
        end
        if (accepted < 10000) checkOutput("timeout", 128'(accepted), 128'(10000));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
